// File: rtl/issueque_div_pkg.sv
// Shared definitions for the divide reservation-station queue.
//   DEF_DEPTH / DEF_DATA_W / DEF_TAG_W : default geometry
//   entry_w()                          : width of one flattened queue entry
//                                        {valid, rs_ready, rs_tag, rs_data,
//                                         rt_ready, rt_tag, rt_data, rdtag}
package issueque_div_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 6;

    // Three single-bit flags (valid, rs_ready, rt_ready), three tags, two operands.
    function automatic int entry_w(input int data_w, input int tag_w);
        return 3 + 3 * tag_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/issueque_div_entry.sv
// One slot of the collapsing divide issue queue.
// Holds an instruction's operands and destination tag, and captures pending
// operands from the CDB. The next-state source is chosen from three places:
// the dispatch port (load_en), the upper neighbour (shift_en, when an older
// entry issues), or the slot's own contents. The CDB capture is then applied
// to whichever source was chosen. This gives dispatch bypass and keeps
// snooping correct while entries shift.
// Ports:
//   clk, reset (async, active-low)
//   clear              drop the entry (flush)
//   load_en, d_*       write a freshly dispatched instruction
//   shift_en, up_entry take the contents of the next-younger slot
//   cdb_*              result broadcast to snoop
//   q_entry            flattened contents, feeds the next-older slot
//   q_ready            valid with both operands available
//   q_rs_data, q_rt_data, q_rdtag  operand and tag fields for the issue mux
module issueque_div_entry
    import issueque_div_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int ENTRY_W = entry_w(DATA_W, TAG_W)
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load_en,
    input  logic               shift_en,
    input  logic               d_rs_ready,
    input  logic [TAG_W-1:0]   d_rs_tag,
    input  logic [DATA_W-1:0]  d_rs_data,
    input  logic               d_rt_ready,
    input  logic [TAG_W-1:0]   d_rt_tag,
    input  logic [DATA_W-1:0]  d_rt_data,
    input  logic [TAG_W-1:0]   d_rdtag,
    input  logic [ENTRY_W-1:0] up_entry,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic [ENTRY_W-1:0] q_entry,
    output logic               q_ready,
    output logic [DATA_W-1:0]  q_rs_data,
    output logic [DATA_W-1:0]  q_rt_data,
    output logic [TAG_W-1:0]   q_rdtag
);

    logic              valid_reg, valid_next;
    logic              rs_ready_reg, rs_ready_next;
    logic [TAG_W-1:0]  rs_tag_reg;
    logic [DATA_W-1:0] rs_data_reg, rs_data_next;
    logic              rt_ready_reg, rt_ready_next;
    logic [TAG_W-1:0]  rt_tag_reg;
    logic [DATA_W-1:0] rt_data_reg, rt_data_next;
    logic [TAG_W-1:0]  rdtag_reg;

    logic              up_valid, up_rs_ready, up_rt_ready;
    logic [TAG_W-1:0]  up_rs_tag, up_rt_tag, up_rdtag;
    logic [DATA_W-1:0] up_rs_data, up_rt_data;

    logic              src_valid, src_rs_ready, src_rt_ready;
    logic [TAG_W-1:0]  src_rs_tag, src_rt_tag, src_rdtag;
    logic [DATA_W-1:0] src_rs_data, src_rt_data;
    logic              rs_hit, rt_hit;

    assign {up_valid, up_rs_ready, up_rs_tag, up_rs_data,
            up_rt_ready, up_rt_tag, up_rt_data, up_rdtag} = up_entry;

    always_comb begin
        src_valid    = valid_reg;
        src_rs_ready = rs_ready_reg;
        src_rs_tag   = rs_tag_reg;
        src_rs_data  = rs_data_reg;
        src_rt_ready = rt_ready_reg;
        src_rt_tag   = rt_tag_reg;
        src_rt_data  = rt_data_reg;
        src_rdtag    = rdtag_reg;
        // Dispatch wins over shift: when an issue and a dispatch happen in the
        // same cycle, the slot being written is the one vacated by the collapse.
        if (load_en) begin
            src_valid    = 1'b1;
            src_rs_ready = d_rs_ready;
            src_rs_tag   = d_rs_tag;
            src_rs_data  = d_rs_data;
            src_rt_ready = d_rt_ready;
            src_rt_tag   = d_rt_tag;
            src_rt_data  = d_rt_data;
            src_rdtag    = d_rdtag;
        end else if (shift_en) begin
            src_valid    = up_valid;
            src_rs_ready = up_rs_ready;
            src_rs_tag   = up_rs_tag;
            src_rs_data  = up_rs_data;
            src_rt_ready = up_rt_ready;
            src_rt_tag   = up_rt_tag;
            src_rt_data  = up_rt_data;
            src_rdtag    = up_rdtag;
        end

        rs_hit = cdb_valid && src_valid && !src_rs_ready && (src_rs_tag == cdb_tag);
        rt_hit = cdb_valid && src_valid && !src_rt_ready && (src_rt_tag == cdb_tag);

        valid_next    = src_valid && !clear;
        rs_ready_next = src_rs_ready || rs_hit;
        rs_data_next  = rs_hit ? cdb_data : src_rs_data;
        rt_ready_next = src_rt_ready || rt_hit;
        rt_data_next  = rt_hit ? cdb_data : src_rt_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg    <= 1'b0;
            rs_ready_reg <= 1'b0;
            rs_tag_reg   <= '0;
            rs_data_reg  <= '0;
            rt_ready_reg <= 1'b0;
            rt_tag_reg   <= '0;
            rt_data_reg  <= '0;
            rdtag_reg    <= '0;
        end else begin
            valid_reg    <= valid_next;
            rs_ready_reg <= rs_ready_next;
            rs_tag_reg   <= src_rs_tag;
            rs_data_reg  <= rs_data_next;
            rt_ready_reg <= rt_ready_next;
            rt_tag_reg   <= src_rt_tag;
            rt_data_reg  <= rt_data_next;
            rdtag_reg    <= src_rdtag;
        end
    end

    assign q_entry   = {valid_reg, rs_ready_reg, rs_tag_reg, rs_data_reg,
                        rt_ready_reg, rt_tag_reg, rt_data_reg, rdtag_reg};
    assign q_ready   = valid_reg && rs_ready_reg && rt_ready_reg;
    assign q_rs_data = rs_data_reg;
    assign q_rt_data = rt_data_reg;
    assign q_rdtag   = rdtag_reg;

endmodule

// File: rtl/issueque_div.sv
// Reservation-station queue for integer divide instructions.
// Holds up to DEPTH instructions in age order. Slot 0 is the oldest. The queue
// collapses: when a slot issues, every younger slot moves down one.
// Missing operands are captured from the CDB. The oldest ready entry is issued
// whenever the divider is not busy.
// Ports:
//   clk, reset (async, active-low)
//   dispatch_*   one instruction per cycle, ignored while queue_full
//   queue_full   registered, count == DEPTH
//   cdb_*        result broadcast
//   flush        drop every entry at the next edge
//   issuediv_busy                       divider back-pressure (combinational)
//   issuediv_enable / _rsdata / _rtdata / _rdtag   issue strobe and payload
//                                                  (payload zero when idle)
module issueque_div
    import issueque_div_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_en,
    input  logic [DATA_W-1:0] dispatch_rsdata,
    input  logic [DATA_W-1:0] dispatch_rtdata,
    input  logic              dispatch_rsready,
    input  logic              dispatch_rtready,
    input  logic [TAG_W-1:0]  dispatch_rstag,
    input  logic [TAG_W-1:0]  dispatch_rttag,
    input  logic [TAG_W-1:0]  dispatch_rdtag,
    output logic              queue_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    input  logic              issuediv_busy,
    output logic              issuediv_enable,
    output logic [DATA_W-1:0] issuediv_rsdata,
    output logic [DATA_W-1:0] issuediv_rtdata,
    output logic [TAG_W-1:0]  issuediv_rdtag
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int SEL_W   = $clog2(DEPTH);
    localparam int ENTRY_W = entry_w(DATA_W, TAG_W);

    logic [ENTRY_W-1:0] q_entry   [DEPTH];
    logic [DATA_W-1:0]  rs_data_q [DEPTH];
    logic [DATA_W-1:0]  rt_data_q [DEPTH];
    logic [TAG_W-1:0]   rdtag_q   [DEPTH];
    logic [DEPTH-1:0]   ready_vec;

    logic [SEL_W-1:0]   sel;
    logic               issue;
    logic               accept;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [CNT_W-1:0]   wr_idx;

    // Oldest-first pick. Readiness comes only from registered state, so a CDB
    // broadcast can make an entry eligible no earlier than the following cycle.
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    assign issue  = (|ready_vec) && !issuediv_busy && !flush;
    assign accept = dispatch_en && !queue_full && !flush;

    // A dispatch lands just above the last live entry. If an issue collapses
    // the queue in the same cycle, that position is one slot lower.
    assign wr_idx = issue ? (count_reg - CNT_W'(1)) : count_reg;

    always_comb begin
        count_next = count_reg + CNT_W'(accept) - CNT_W'(issue);
        if (flush) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign queue_full = (count_reg == CNT_W'(DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [ENTRY_W-1:0] up_entry;
            logic               shift_en;
            logic               load_en;

            if (gi == DEPTH - 1) begin : g_top
                assign up_entry = '0;
            end else begin : g_mid
                assign up_entry = q_entry[gi + 1];
            end

            assign shift_en = issue && (SEL_W'(gi) >= sel);
            assign load_en  = accept && (wr_idx == CNT_W'(gi));

            issueque_div_entry #(
                .DATA_W (DATA_W),
                .TAG_W  (TAG_W)
            ) u_entry (
                .clk        (clk),
                .reset      (reset),
                .clear      (flush),
                .load_en    (load_en),
                .shift_en   (shift_en),
                .d_rs_ready (dispatch_rsready),
                .d_rs_tag   (dispatch_rstag),
                .d_rs_data  (dispatch_rsdata),
                .d_rt_ready (dispatch_rtready),
                .d_rt_tag   (dispatch_rttag),
                .d_rt_data  (dispatch_rtdata),
                .d_rdtag    (dispatch_rdtag),
                .up_entry   (up_entry),
                .cdb_valid  (cdb_valid),
                .cdb_tag    (cdb_tag),
                .cdb_data   (cdb_data),
                .q_entry    (q_entry[gi]),
                .q_ready    (ready_vec[gi]),
                .q_rs_data  (rs_data_q[gi]),
                .q_rt_data  (rt_data_q[gi]),
                .q_rdtag    (rdtag_q[gi])
            );
        end
    endgenerate

    assign issuediv_enable = issue;
    assign issuediv_rsdata = issue ? rs_data_q[sel] : '0;
    assign issuediv_rtdata = issue ? rt_data_q[sel] : '0;
    assign issuediv_rdtag  = issue ? rdtag_q[sel]   : '0;

endmodule
